// File: rtl/si570_freq_prog_if.sv
// si570_freq_prog_if: command/readback bus between the Si570 programmer and the shared I2C engine
interface si570_freq_prog_if;
  logic [36:0] i2ccmd;
  logic        i2cstart;
  logic        i2cbusy;
  logic [37:0] rfreq_now;
  logic        rb_valid;
  modport master (output i2ccmd, i2cstart, input i2cbusy, rfreq_now, rb_valid);
  modport slave (input i2ccmd, i2cstart, output i2cbusy, rfreq_now, rb_valid);
endinterface

// File: rtl/si570_freq_prog.sv
// si570_freq_prog: sequences I2C commands that retune an Si570, stepping small RFREQ changes
module si570_freq_prog #(
  parameter logic [6:0] DEV_ADDR = 7'h5d,
  parameter logic [6:0] MUX_ADDR = 7'h74,
  parameter logic [7:0] MUX_CH = 8'h01,
  parameter int SETTLE = 5,
  parameter int TIMEOUT = 65535,
  parameter int STEP_SHIFT = 9,
  parameter int MAX_STEPS = 63
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  smallchange,
  input  logic [2:0]            hs_div,
  input  logic [6:0]            n1,
  input  logic [37:0]           rfreq,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            step_cnt,
  si570_freq_prog_if.master     bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam logic [CW-1:0] STL = CW'(SETTLE);
  localparam logic [7:0] MAXS = 8'(MAX_STEPS);
  typedef enum logic [3:0] {IDLE, MUXSEL, CALC, FRZ, R7, R8, R9, RA, RB, RC, UNFRZ, NEWF, WAITRB, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic small_q, small_d, last_q, last_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic istart_q, istart_d;
  logic [2:0] hs_q, hs_d;
  logic [6:0] n1_q, n1_d;
  logic [37:0] tgt_q, tgt_d, rw_q, rw_d;
  logic [7:0] step_q, step_d;
  logic [36:0] cmd_q, cmd_d;
  logic [38:0] diff, mag;
  logic [37:0] lim, stepped;
  logic in_rng, adv, tmo;
  function automatic logic [36:0] dev_cmd(input logic [7:0] a, input logic [7:0] b);
    return {1'b1, 4'd3, DEV_ADDR, 1'b0, a, b, 8'h00};
  endfunction
  assign diff = {1'b0, tgt_q} - {1'b0, bus.rfreq_now};
  assign mag = diff[38] ? -diff : diff;
  assign lim = bus.rfreq_now >> STEP_SHIFT;
  assign in_rng = mag <= {1'b0, lim};
  assign stepped = diff[38] ? bus.rfreq_now - lim : bus.rfreq_now + lim;
  assign adv = cnt_q > STL && !bus.i2cbusy;
  assign tmo = cnt_q == TMO && (state_q == WAITRB ? !bus.rb_valid : cmd_q[36] && bus.i2cbusy);
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign step_cnt = step_q;
  assign bus.i2ccmd = cmd_q;
  assign bus.i2cstart = istart_q;
  // next-state, step arithmetic and the registered command for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q == TMO ? cnt_q : cnt_q + CW'(1);
    small_d = small_q;
    hs_d = hs_q;
    n1_d = n1_q;
    tgt_d = tgt_q;
    rw_d = rw_q;
    last_d = last_q;
    err_d = err_q;
    step_d = step_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = MUXSEL;
        small_d = smallchange;
        hs_d = hs_div;
        n1_d = n1;
        tgt_d = rfreq;
        err_d = 1'b0;
        step_d = 8'd0;
      end
      MUXSEL: state_d = adv ? CALC : state_q;
      CALC: begin
        state_d = FRZ;
        rw_d = !small_q || in_rng ? tgt_q : stepped;
        last_d = !small_q || in_rng;
        step_d = small_q ? step_q + 8'd1 : step_q;
      end
      FRZ: state_d = adv ? (small_q ? R8 : R7) : state_q;
      R7, R8, R9, RA, RB, RC: state_d = adv ? state_t'(state_q + 4'd1) : state_q;
      UNFRZ: if (adv) begin
        state_d = !small_q ? NEWF : last_q ? DONE : step_q == MAXS ? IDLE : WAITRB;
        err_d = small_q && !last_q && step_q == MAXS;
      end
      NEWF: state_d = adv ? DONE : state_q;
      WAITRB: state_d = bus.rb_valid && !bus.i2cbusy ? MUXSEL : state_q;
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
    if (state_d != state_q) cnt_d = '0;
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
    case (state_d)
      MUXSEL: cmd_d = {1'b1, 4'd2, MUX_ADDR, 1'b0, MUX_CH, 16'h0000};
      FRZ: cmd_d = small_q ? dev_cmd(8'd135, 8'h20) : dev_cmd(8'd137, 8'h10);
      R7: cmd_d = dev_cmd(8'h07, {hs_q, n1_q[6:2]});
      R8: cmd_d = dev_cmd(8'h08, {n1_q[1:0], rw_q[37:32]});
      R9: cmd_d = dev_cmd(8'h09, rw_q[31:24]);
      RA: cmd_d = dev_cmd(8'h0a, rw_q[23:16]);
      RB: cmd_d = dev_cmd(8'h0b, rw_q[15:8]);
      RC: cmd_d = dev_cmd(8'h0c, rw_q[7:0]);
      UNFRZ: cmd_d = small_q ? dev_cmd(8'd135, 8'h00) : dev_cmd(8'd137, 8'h00);
      NEWF: cmd_d = dev_cmd(8'd135, 8'h40);
      default: cmd_d = '0;
    endcase
    istart_d = cmd_d[36] && state_d != state_q;
  end
  // state and registered outputs; async reset aborts any sequence in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      small_q <= 1'b0;
      hs_q <= '0;
      n1_q <= '0;
      tgt_q <= '0;
      rw_q <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      step_q <= '0;
      cmd_q <= '0;
      istart_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      small_q <= small_d;
      hs_q <= hs_d;
      n1_q <= n1_d;
      tgt_q <= tgt_d;
      rw_q <= rw_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      step_q <= step_d;
      cmd_q <= cmd_d;
      istart_q <= istart_d;
    end
  end
endmodule

// File: tb/tb_si570_freq_prog.sv
// tb_si570_freq_prog: directed tests of the Si570 programmer against a behavioural I2C engine
module tb_si570_freq_prog;
  localparam logic [37:0] N = 38'h2BC0000000;
  localparam logic [37:0] L0 = 38'h0015E00000;
  localparam logic [36:0] MUXC = {1'b1, 4'd2, 7'h74, 1'b0, 8'h01, 16'h0000};
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, smallchange = 1'b0;
  logic [2:0] hs_div = '0;
  logic [6:0] n1 = '0;
  logic [37:0] rfreq = '0;
  logic busy, done, err;
  logic [7:0] step_cnt;
  logic ebusy = 1'b0, load = 1'b0, rbv = 1'b0;
  logic [37:0] base = '0, shadow = '0, wr = '0;
  si570_freq_prog_if bif();
  assign bif.i2cbusy = ebusy;
  assign bif.rfreq_now = shadow;
  assign bif.rb_valid = rbv;
  si570_freq_prog dut (
    .clk(clk), .rst(rst), .start(start), .smallchange(smallchange), .hs_div(hs_div), .n1(n1),
    .rfreq(rfreq), .busy(busy), .done(done), .err(err), .step_cnt(step_cnt), .bus(bif));
  logic start2 = 1'b0, sc2 = 1'b0, ebusy2 = 1'b0;
  logic [2:0] hs2 = 3'd3;
  logic [6:0] n12 = 7'd7;
  logic [37:0] rfreq2 = '0, now2 = '0;
  logic busy2, done2, err2;
  logic [7:0] step2;
  si570_freq_prog_if bif2();
  assign bif2.i2cbusy = ebusy2;
  assign bif2.rfreq_now = now2;
  assign bif2.rb_valid = 1'b1;
  si570_freq_prog #(.TIMEOUT(100), .MAX_STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .smallchange(sc2), .hs_div(hs2), .n1(n12),
    .rfreq(rfreq2), .busy(busy2), .done(done2), .err(err2), .step_cnt(step2), .bus(bif2));
  int checks = 0, fails = 0, cyc = 0, p2 = 0;
  logic [36:0] cmds[$];
  int stamps[$];
  // engine model: logs commands, assembles written RFREQ, presents it as readback after unfreeze
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif2.i2cstart) p2 <= p2 + 1;
    if (bif.i2cstart) begin
      cmds.push_back(bif.i2ccmd);
      stamps.push_back(cyc);
    end
    if (load) begin
      shadow <= base;
      rbv <= 1'b1;
    end else if (bif.i2cstart && bif.i2ccmd[31:25] == 7'h5d) begin
      if (bif.i2ccmd[23:16] == 8'h08) wr[37:32] <= bif.i2ccmd[13:8];
      if (bif.i2ccmd[23:16] == 8'h09) wr[31:24] <= bif.i2ccmd[15:8];
      if (bif.i2ccmd[23:16] == 8'h0a) wr[23:16] <= bif.i2ccmd[15:8];
      if (bif.i2ccmd[23:16] == 8'h0b) wr[15:8] <= bif.i2ccmd[15:8];
      if (bif.i2ccmd[23:16] == 8'h0c) wr[7:0] <= bif.i2ccmd[15:8];
      if (bif.i2ccmd[23:8] == {8'd135, 8'h20}) rbv <= 1'b0;
      if (bif.i2ccmd[23:8] == {8'd135, 8'h00}) begin
        shadow <= wr;
        rbv <= 1'b1;
      end
    end
  end
  function automatic logic [36:0] dc(input logic [7:0] a, input logic [7:0] b);
    return {1'b1, 4'd3, 7'h5d, 1'b0, a, b, 8'h00};
  endfunction
  task automatic load_now(input logic [37:0] v);
    base = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask
  task automatic run(input logic sc, input logic [2:0] h, input logic [6:0] n, input logic [37:0] r,
                     input int poke, output int dn, output int n0, output bit to);
    n0 = cmds.size();
    smallchange = sc;
    hs_div = h;
    n1 = n;
    rfreq = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (done) dn++;
      if (!busy) begin
        to = 1'b0;
        break;
      end
      start = i == poke;
      if (i == poke) begin
        smallchange = ~sc;
        hs_div = ~h;
        n1 = ~n;
        rfreq = '0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, step_cnt, bif.i2cstart, bif.i2ccmd} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, err, step_cnt, bif.i2cstart, bif.i2ccmd});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, bif.i2cstart} !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle: got %b want 0000", {busy, done, err, bif.i2cstart});
    end
  endtask
  task automatic test_large;
    int dn, n0, mn;
    bit to;
    logic [36:0] exp[10];
    logic [36:0] got;
    exp = '{MUXC, dc(137, 8'h10), dc(7, 8'h61), dc(8, 8'hEB), dc(9, 8'hC0), dc(10, 8'h00),
            dc(11, 8'h00), dc(12, 8'h00), dc(137, 8'h00), dc(135, 8'h40)};
    load_now(N);
    run(1'b0, 3'd3, 7'd7, N, -1, dn, n0, to);
    checks++;
    if (to !== 1'b0 || dn !== 1) begin
      fails++;
      $display("FAIL large_done: timeout=%0d done_pulses=%0d want 0/1", to, dn);
    end
    checks++;
    if (cmds.size() - n0 !== 10) begin
      fails++;
      $display("FAIL large_count: got %0d want 10", cmds.size() - n0);
    end
    for (int i = 0; i < 10; i++) begin
      got = n0 + i < cmds.size() ? cmds[n0 + i] : '0;
      checks++;
      if (got !== exp[i]) begin
        fails++;
        $display("FAIL large_cmd%0d: got %h want %h", i, got, exp[i]);
      end
    end
    mn = 1000;
    for (int i = n0 + 1; i < stamps.size(); i++) mn = stamps[i] - stamps[i-1] < mn ? stamps[i] - stamps[i-1] : mn;
    checks++;
    if (mn !== 7) begin
      fails++;
      $display("FAIL large_spacing: min gap %0d want 7", mn);
    end
    checks++;
    if ({err, step_cnt} !== 9'd0) begin
      fails++;
      $display("FAIL large_err_steps: err=%b steps=%0d want 0/0", err, step_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL large_done_width: done,busy=%b want 00", {done, busy});
    end
  endtask
  task automatic test_small_in;
    int dn, n0;
    bit to;
    logic [36:0] exp[8];
    logic [36:0] got;
    exp = '{MUXC, dc(135, 8'h20), dc(8, 8'hEB), dc(9, 8'hC0), dc(10, 8'h10), dc(11, 8'h00),
            dc(12, 8'h00), dc(135, 8'h00)};
    load_now(N);
    run(1'b1, 3'd3, 7'd7, N + 38'h100000, -1, dn, n0, to);
    checks++;
    if (to !== 1'b0 || dn !== 1 || step_cnt !== 8'd1 || err !== 1'b0) begin
      fails++;
      $display("FAIL small_in: timeout=%0d done=%0d steps=%0d err=%b want 0/1/1/0", to, dn, step_cnt, err);
    end
    checks++;
    if (cmds.size() - n0 !== 8) begin
      fails++;
      $display("FAIL small_in_count: got %0d want 8", cmds.size() - n0);
    end
    for (int i = 0; i < 8; i++) begin
      got = n0 + i < cmds.size() ? cmds[n0 + i] : '0;
      checks++;
      if (got !== exp[i]) begin
        fails++;
        $display("FAIL small_in_cmd%0d: got %h want %h", i, got, exp[i]);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_small_steps;
    int dn, n0;
    bit to;
    load_now(N);
    run(1'b1, 3'd3, 7'd7, 38'h2C01A00000, -1, dn, n0, to);
    checks++;
    if (to !== 1'b0 || dn !== 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL steps_done: timeout=%0d done=%0d err=%b want 0/1/0", to, dn, err);
    end
    checks++;
    if (step_cnt !== 8'd3) begin
      fails++;
      $display("FAIL steps_count: got %0d want 3", step_cnt);
    end
    checks++;
    if (cmds.size() - n0 !== 24) begin
      fails++;
      $display("FAIL steps_cmds: got %0d want 24", cmds.size() - n0);
    end
    checks++;
    if (bif.rfreq_now !== 38'h2C01A00000) begin
      fails++;
      $display("FAIL steps_final: got %h want 2c01a00000", bif.rfreq_now);
    end
    @(negedge clk);
  endtask
  task automatic test_overrun;
    int dn, p0;
    bit to;
    now2 = N;
    rfreq2 = N + 38'd10 * L0;
    sc2 = 1'b1;
    p0 = p2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    dn = 0;
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (done2) dn++;
      if (!busy2) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (to !== 1'b0 || err2 !== 1'b1 || dn !== 0) begin
      fails++;
      $display("FAIL overrun_err: timeout=%0d err=%b done=%0d want 0/1/0", to, err2, dn);
    end
    checks++;
    if (step2 !== 8'd2 || p2 - p0 !== 16) begin
      fails++;
      $display("FAIL overrun_steps: steps=%0d pulses=%0d want 2/16", step2, p2 - p0);
    end
  endtask
  task automatic test_timeout;
    int k, dn;
    sc2 = 1'b0;
    rfreq2 = N;
    ebusy2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checks++;
    if (bif2.i2cstart !== 1'b1 || err2 !== 1'b0) begin
      fails++;
      $display("FAIL tmo_start: i2cstart=%b err=%b want 1/0", bif2.i2cstart, err2);
    end
    ebusy2 = 1'b1;
    k = 0;
    dn = 0;
    for (int i = 0; i < 300 && !err2; i++) begin
      @(negedge clk);
      k++;
      if (done2) dn++;
    end
    checks++;
    if (k !== 101) begin
      fails++;
      $display("FAIL tmo_cycles: got %0d want 101", k);
    end
    checks++;
    if (bif2.i2ccmd !== '0 || busy2 !== 1'b0 || dn !== 0) begin
      fails++;
      $display("FAIL tmo_outputs: cmd=%h busy=%b done=%0d want 0/0/0", bif2.i2ccmd, busy2, dn);
    end
    @(negedge clk);
    checks++;
    if (err2 !== 1'b1) begin
      fails++;
      $display("FAIL tmo_sticky: err=%b want 1", err2);
    end
    ebusy2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checks++;
    if (err2 !== 1'b0 || busy2 !== 1'b1) begin
      fails++;
      $display("FAIL tmo_clear: err=%b busy=%b want 0/1", err2, busy2);
    end
    for (int i = 0; i < 400 && busy2; i++) @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin
      fails++;
      $display("FAIL tmo_rerun: busy=%b want 0", busy2);
    end
  endtask
  task automatic test_rst_mid;
    int n0;
    bit seen;
    load_now(N);
    smallchange = 1'b0;
    hs_div = 3'd3;
    n1 = 7'd7;
    rfreq = N;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bif.i2cstart && bif.i2ccmd[23:16] == 8'h09;
    end
    checks++;
    if (seen !== 1'b1) begin
      fails++;
      $display("FAIL rst_reach_r9: got %b want 1", seen);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, step_cnt, bif.i2cstart, bif.i2ccmd} !== '0) begin
      fails++;
      $display("FAIL rst_async: got %h want 0", {busy, done, err, step_cnt, bif.i2cstart, bif.i2ccmd});
    end
    @(negedge clk);
    rst = 1'b0;
    n0 = cmds.size();
    repeat (20) @(negedge clk);
    checks++;
    if (cmds.size() !== n0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_stays_idle: new cmds=%0d busy=%b want 0/0", cmds.size() - n0, busy);
    end
  endtask
  task automatic test_back_to_back;
    int dn, n0;
    bit to;
    logic [36:0] got;
    load_now(N);
    run(1'b0, 3'd3, 7'd7, N, 3, dn, n0, to);
    got = n0 + 2 < cmds.size() ? cmds[n0 + 2] : '0;
    checks++;
    if (to !== 1'b0 || dn !== 1 || cmds.size() - n0 !== 10) begin
      fails++;
      $display("FAIL b2b_ignore: timeout=%0d done=%0d cmds=%0d want 0/1/10", to, dn, cmds.size() - n0);
    end
    checks++;
    if (got !== dc(7, 8'h61)) begin
      fails++;
      $display("FAIL b2b_r7_latched: got %h want %h", got, dc(7, 8'h61));
    end
    @(negedge clk);
    run(1'b0, 3'd5, 7'h55, N, -1, dn, n0, to);
    got = n0 + 2 < cmds.size() ? cmds[n0 + 2] : '0;
    checks++;
    if (to !== 1'b0 || dn !== 1 || got !== dc(7, 8'hB5)) begin
      fails++;
      $display("FAIL b2b_second_r7: timeout=%0d done=%0d got %h want 0/1/%h", to, dn, got, dc(7, 8'hB5));
    end
    got = n0 + 3 < cmds.size() ? cmds[n0 + 3] : '0;
    checks++;
    if (got !== dc(8, 8'h6B)) begin
      fails++;
      $display("FAIL b2b_second_r8: got %h want %h", got, dc(8, 8'h6B));
    end
    @(negedge clk);
  endtask
  initial begin
    #2;
    test_reset;
    test_large;
    test_small_in;
    test_small_steps;
    test_overrun;
    test_timeout;
    test_rst_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
